// File: rtl/mfm_pkg.sv
// Shared MFM definitions for the shifter and the read-side decoder.
// Interval limits are in half-cell clocks.
package mfm_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    MEASURE = 1'b1
  } mfm_state_e;

  localparam int MFM_MIN_INT = 2;
  localparam int MFM_MAX_INT = 5;
  localparam int PULSE_W     = 3;

endpackage

// File: rtl/mfm_out_reg.sv
// One-entry valid/ready holding register for decoded intervals.
// A load into a full, stalled register is dropped and flagged.
module mfm_out_reg
  import mfm_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_i,
  input  logic [PULSE_W-1:0] din_i,
  input  logic               ready_i,
  output logic [PULSE_W-1:0] pulses_o,
  output logic               valid_o,
  output logic               overrun_o
);

  logic [PULSE_W-1:0] pulses_q, pulses_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;
  logic               drain;

  // Slot frees on this edge if the consumer takes it.
  assign drain = valid_q && ready_i;

  always_comb begin
    pulses_d = pulses_q;
    valid_d  = valid_q;
    ovr_d    = 1'b0;
    if (load_i) begin
      if (!valid_q || drain) begin
        pulses_d = din_i;
        valid_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulses_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      pulses_q <= pulses_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign pulses_o  = pulses_q;
  assign valid_o   = valid_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/mfm_interval_decoder.sv
// Measures spacing between MFM flux transitions, one half-cell per clock.
// Intervals leave through mfm_out_reg; bad spacings raise error.
module mfm_interval_decoder
  import mfm_pkg::*;
#(
  parameter int MIN_INT = MFM_MIN_INT,
  parameter int MAX_INT = MFM_MAX_INT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               si,
  output logic [PULSE_W-1:0] pulses,
  output logic               valid,
  input  logic               ready,
  output logic               error,
  output logic               overrun,
  output logic               locked
);

  localparam logic [PULSE_W-1:0] MinC = PULSE_W'(MIN_INT);
  localparam logic [PULSE_W-1:0] MaxC = PULSE_W'(MAX_INT);

  mfm_state_e         state_q, state_d;
  logic [PULSE_W-1:0] cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               lock_q;
  logic               emit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    emit    = 1'b0;
    if (!enable) begin
      state_d = HUNT;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        HUNT: begin
          if (si) begin
            state_d = MEASURE;
            cnt_d   = PULSE_W'(1);
          end
        end
        MEASURE: begin
          if (si) begin
            cnt_d = PULSE_W'(1);
            if (cnt_q >= MinC) emit  = 1'b1;
            else               err_d = 1'b1;
          end else if (cnt_q == MaxC) begin
            // Spacing would exceed the legal maximum: sync lost.
            err_d   = 1'b1;
            state_d = HUNT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + PULSE_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      lock_q  <= (state_d == MEASURE);
    end
  end

  mfm_out_reg u_out (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (emit),
    .din_i     (cnt_q),
    .ready_i   (ready),
    .pulses_o  (pulses),
    .valid_o   (valid),
    .overrun_o (overrun)
  );

  assign error  = err_q;
  assign locked = lock_q;

endmodule

// File: tb/tb_mfm_interval_decoder.sv
// Bench for mfm_interval_decoder: directed scenarios plus random flux,
// compared each cycle against a transition-timestamp reference model.
module tb_mfm_interval_decoder;

  localparam int MIN = 2;
  localparam int MAX = 5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       si = 1'b0;
  logic       ready = 1'b0;
  logic [2:0] pulses;
  logic       valid, error, overrun, locked;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int         t = 0;
  int         last_t = 0;
  bit         hunting = 1'b1;
  bit         m_valid = 1'b0;
  logic [2:0] m_pulses = '0;
  bit         m_err = 1'b0;
  bit         m_ovr = 1'b0;

  mfm_interval_decoder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .si      (si),
    .pulses  (pulses),
    .valid   (valid),
    .ready   (ready),
    .error   (error),
    .overrun (overrun),
    .locked  (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got %0d want %0d", tag, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    hunting  = 1'b1;
    m_valid  = 1'b0;
    m_pulses = '0;
    m_err    = 1'b0;
    m_ovr    = 1'b0;
  endtask

  // Interval = distance in sampled cells between two transitions.
  task automatic model_edge(input bit s, input bit e, input bit r);
    bit emit = 1'b0;
    int gap;
    m_err = 1'b0;
    m_ovr = 1'b0;
    if (!e) begin
      hunting = 1'b1;
    end else if (hunting) begin
      if (s) begin
        hunting = 1'b0;
        last_t  = t;
      end
    end else begin
      gap = t - last_t;
      if (s) begin
        if (gap < MIN) m_err = 1'b1;
        else           emit  = 1'b1;
        last_t = t;
      end else if (gap >= MAX) begin
        m_err   = 1'b1;
        hunting = 1'b1;
      end
    end
    if (emit) begin
      if (!m_valid || r) begin
        m_pulses = 3'(gap);
        m_valid  = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
    t++;
  endtask

  task automatic check_all();
    chk("valid", valid, m_valid);
    if (m_valid) chk("pulses", pulses, m_pulses);
    chk("error", error, m_err);
    chk("overrun", overrun, m_ovr);
    chk("locked", locked, !hunting);
  endtask

  task automatic step(input bit s, input bit e, input bit r);
    si     = s;
    enable = e;
    ready  = r;
    @(posedge clk);
    model_edge(s, e, r);
    #1 check_all();
  endtask

  task automatic run_bits(input logic [15:0] b, input int n, input bit r);
    for (int i = 0; i < n; i++) step(b[n-1-i], 1'b1, r);
  endtask

  initial begin
    #12;
    chk("rst_valid", valid, 0);
    chk("rst_pulses", pulses, 0);
    chk("rst_locked", locked, 0);
    chk("rst_error", error, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // 2,3,5 with ready high
    run_bits(16'b101_0010_0001, 11, 1'b1);
    chk("seq_last_pulses", pulses, 5);
    // short interval then resync
    run_bits(16'b11, 2, 1'b1);
    run_bits(16'b01, 2, 1'b1);
    chk("resync_pulses", pulses, 2);
    // over-long gap, then relock
    run_bits(16'b0000000, 7, 1'b1);
    chk("lost_lock", locked, 0);
    run_bits(16'b1001, 4, 1'b1);
    chk("relock_pulses", pulses, 3);
    step(1'b0, 1'b0, 1'b1);
    // stalled consumer: overrun
    run_bits(16'b101001, 6, 1'b0);
    chk("held_pulses", pulses, 2);
    step(1'b0, 1'b1, 1'b1);
    chk("drain_pulses", pulses, 2);
    step(1'b0, 1'b0, 1'b1);
    // simultaneous consume and load of 4
    run_bits(16'b1010001, 7, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    run_bits(16'b10100, 5, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("swap_pulses", pulses, 4);

    // async reset mid-interval with valid pending
    run_bits(16'b10100, 5, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_pulses", pulses, 0);
    chk("arst_locked", locked, 0);
    chk("arst_error", error, 0);
    model_reset();
    #2 reset_n = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    chk("post_rst_valid", valid, 0);

    // random flux, occasional disable and stalls
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 35,
           $urandom_range(0, 39) != 0,
           $urandom_range(0, 99) < 70);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mfm_interval_decoder.md
# mfm_interval_decoder

Read-side counterpart of the MFM shifter: samples the serial MFM flux stream one half-cell per clock, measures the spacing between consecutive transitions, and returns each spacing as a 3-bit `pulses` code. This is the same encoding the shifter's `pulses` input accepts. It sits between the disk read-data input and the MFM bit/sync decoder. Decoded intervals go out on a valid/ready handshake, with out-of-range spacings and overruns flagged.

## Interface
- `MIN_INT`, 2, smallest legal interval in clocks; shorter spacing is an error.
- `MAX_INT`, 5, largest legal interval in clocks; must be ≤ 7. Exceeding it is a loss-of-sync error.
- `clk` in 1: system clock; one half-cell per cycle.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: decoder run; low forces HUNT.
- `si` in 1: serial flux input; 1 marks a transition in this cell.
- `pulses` out 3: decoded interval in clocks. Reset 0.
- `valid` out 1: `pulses` holds an unconsumed interval. Reset 0.
- `ready` in 1: consumer accepts `pulses` when `valid && ready`.
- `error` out 1: one-cycle pulse on an interval shorter than MIN_INT or longer than MAX_INT. Reset 0.
- `overrun` out 1: one-cycle pulse when an interval is dropped because the output is full. Reset 0.
- `locked` out 1: high in MEASURE. Reset 0.

## Operation
- `si` is sampled at every rising `clk`. Interval = number of edges from one transition to the next, so "1,0,1" gives 2.
- Internal counter `cnt` is 3 bits wide; reset value 0.
- State HUNT (reset state): `cnt` is held at 0. When `enable && si`, set `cnt <= 1` and go to MEASURE.
- State MEASURE, on each edge:
  - `si=1` and `cnt ≥ MIN_INT`: emit interval = `cnt`; set `cnt <= 1`; stay in MEASURE.
  - `si=1` and `cnt < MIN_INT`: pulse `error`; emit nothing; set `cnt <= 1`. The new transition resynchronises, so stay in MEASURE.
  - `si=0` and `cnt == MAX_INT`: pulse `error`; go to HUNT; set `cnt <= 0`.
  - `si=0` otherwise: `cnt <= cnt + 1`.
- `enable` low in any state: go to HUNT next edge; clear `cnt`. No `error` is raised. The output register and `valid` are untouched.
- Emitting an interval:
  - If `valid=0`, or `valid && ready` on the same edge: load `pulses` and hold or set `valid=1`. Simultaneous consume and load is lossless.
  - If `valid && !ready`: keep the old `pulses`, drop the new interval, pulse `overrun`.
- `valid && ready` with nothing emitted: `valid <= 0`; `pulses` keeps its value.
- `error` and `overrun` can pulse on the same edge only if a short-interval error coincides with a full output. In that case only `error` pulses, because nothing is emitted.

## Timing
- Latency: `pulses`/`valid` update on the same edge that samples the terminating `si=1`. They are visible the cycle after the transition is presented.
- `error`, `overrun` and `locked` are registered and change on that same edge.
- Throughput: one interval per MIN_INT clocks maximum. The handshake sustains it with `ready` held high.
- `reset_n` asserted mid-operation: all registers take reset values immediately, asynchronously. A pending interval is lost. After release, the decoder starts in HUNT.
- `ready` is don't-care while `valid=0`.

## Structure
- Shared package `mfm_pkg`: state enum (HUNT, MEASURE); MFM interval constants MFM_MIN_INT=2, MFM_MAX_INT=5; `pulses` width constant PULSE_W=3. These are shared with the shifter.
- One sub-module: `mfm_out_reg`. It is a one-entry valid/ready holding register with the drop/overrun logic. The top level holds the FSM and counter.

## Test plan
- Reset, then `enable=1`, `ready=1`, `si` = 1,0,1,0,0,1,0,0,0,0,1 → `pulses` sequence 2, 3, 5, each `valid` for one cycle; `error` never pulses; `locked` high from the second edge.
- `si` = 1,1 in MEASURE → `error` pulses once, no `valid`. Then 0,1 → `pulses=2` valid, showing resync.
- `si` = 1 followed by six 0s → `error` pulse on the edge sampling the 5th zero, `locked` drops. A later 1,0,0,1 gives `pulses=3`.
- `ready=0`, `si` = 1,0,1,0,0,1 → first `pulses=2` held with `valid=1`; second interval (3) dropped with one `overrun` pulse. Raise `ready` → `valid` clears, `pulses` stays 2.
- `ready` high on the exact edge a new interval of 4 arrives while 2 is pending → `pulses` becomes 4, `valid` stays 1, no `overrun`.
- Assert `reset_n=0` mid-interval with `valid=1` → `valid`, `pulses`, `locked`, `error` go 0 without waiting for `clk`. After release, the first `si=1` produces no output.
